// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB master arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  typedef logic grant_idx_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter. A masked request is invisible, and the
// last-grant state moves only when the caller accepts the grant (take).
module apb_rr_arbiter
  import apb_arb_pkg::*;
(
  input  logic       pclk,
  input  logic       preset,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       take,
  output logic       gnt_vld,
  output grant_idx_t gnt_idx
);

  grant_idx_t last_q;
  logic [1:0] eff;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      last_q <= 1'b1;
    end else if (take) begin
      last_q <= gnt_idx;
    end
  end

  // On a tie, the requester that was not granted last wins.
  always_comb begin
    eff     = req & ~mask;
    gnt_vld = |eff;
    gnt_idx = (&eff) ? ~last_q : eff[1];
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbitration of two requesters onto one APB master port.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic                  req0_write,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic                  req1_write,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata
);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_t state_q, state_d;
  grant_idx_t owner_q, gnt_idx;
  logic       gnt_vld, take, cmpl, tmo;
  logic [1:0] mask;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_SETUP) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_ACCESS && !pready && tmo_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // A slave that answers in the limit cycle still completes normally.
  assign tmo = (state_q == ST_ACCESS) && !pready && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
  assign tmo = 1'b0;
`endif

  assign cmpl = (state_q == ST_ACCESS) && (pready || tmo);
  // The completing owner's still-high valid must not win the next grant.
  assign mask = (state_q == ST_ACCESS) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign take = gnt_vld && ((state_q == ST_IDLE) || cmpl);

  apb_rr_arbiter u_rr (
    .pclk    (pclk),
    .preset  (preset),
    .req     ({req1_valid, req0_valid}),
    .mask    (mask),
    .take    (take),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (gnt_vld) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (cmpl) state_d = gnt_vld ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      owner_q <= 1'b0;
      paddr   <= '0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
    end else if (take) begin
      owner_q <= gnt_idx;
      paddr   <= gnt_idx ? req1_addr  : req0_addr;
      pwrite  <= gnt_idx ? req1_write : req0_write;
      pwdata  <= gnt_idx ? req1_wdata : req0_wdata;
    end
  end

  assign psel       = (state_q != ST_IDLE);
  assign penable    = (state_q == ST_ACCESS);
  assign req0_done  = cmpl && !owner_q;
  assign req1_done  = cmpl && owner_q;
  assign req0_rdata = (req0_done && !tmo) ? prdata : '0;
  assign req1_rdata = (req1_done && !tmo) ? prdata : '0;
  assign req0_err   = req0_done && tmo;
  assign req1_err   = req1_done && tmo;

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB and requester address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB and requester data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-phase cycles (used only under APB_ARB_TIMEOUT_EN).
REQ-004 SHALL have one clock and an asynchronous active-high reset:
- pclk  input  1  clock, all state on rising edge.
- preset  input  1  asynchronous active-high reset.
REQ-005 SHALL have, for each requester N in {0,1}:
- reqN_valid  input  1  request pending; held with fields stable until reqN_done.
- reqN_addr  input  ADDR_WIDTH  target address.
- reqN_write  input  1  1=write, 0=read.
- reqN_wdata  input  DATA_WIDTH  write data.
- reqN_done  output  1  single-cycle completion strobe.
- reqN_rdata  output  DATA_WIDTH  read data, valid only while reqN_done=1.
- reqN_err  output  1  timeout flag, valid only while reqN_done=1.
REQ-006 SHALL drive the APB master side:
- paddr  output  ADDR_WIDTH  address.
- psel  output  1  select.
- penable  output  1  enable.
- pwrite  output  1  direction.
- pwdata  output  DATA_WIDTH  write data.
- pready  input  1  slave ready.
- prdata  input  DATA_WIDTH  slave read data.

Function
REQ-007 SHALL implement FSM states IDLE (psel=0, penable=0), SETUP (psel=1, penable=0) and ACCESS (psel=1, penable=1).
REQ-008 In IDLE, when any reqN_valid=1, SHALL grant one requester, latch its addr/write/wdata into paddr/pwrite/pwdata and enter SETUP in the next cycle.
REQ-009 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; after reset requester 0 wins first.
REQ-010 SETUP SHALL always advance to ACCESS after exactly one cycle.
REQ-011 ACCESS SHALL remain while pready=0; paddr/pwrite/pwdata/psel SHALL stay stable for the whole transfer.
REQ-012 In the ACCESS cycle with pready=1, owner's reqN_done SHALL be 1 (combinational), reqN_rdata SHALL equal prdata and reqN_err SHALL be 0.
REQ-013 In the completing cycle, if the non-owner's valid=1 the FSM SHALL grant it, latch its fields and go directly to SETUP; otherwise it SHALL go to IDLE.
REQ-014 The owner's valid in its completing cycle SHALL NOT be treated as a new request.
REQ-015 Minimum latency: valid in IDLE cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> done in cycle 2 if pready=1.
REQ-016 reqN_done SHALL be 0 for the non-owner and outside ACCESS completion; reqN_rdata SHALL be 0 when reqN_done=0.
REQ-017 paddr/pwrite/pwdata SHALL hold the last transfer's values in IDLE.

Reset
REQ-018 preset=1 SHALL immediately (asynchronously) force state IDLE, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, all done/err=0 and last-grant=1.
REQ-019 Reset mid-transfer SHALL abort without any done strobe; the requester reissues after reset.

Configuration
REQ-020 With APB_ARB_TIMEOUT_EN defined, a counter SHALL clear on SETUP and increment each ACCESS cycle with pready=0.
REQ-021 With APB_ARB_TIMEOUT_EN defined, at count TIMEOUT_CYCLES the transfer SHALL end with reqN_done=1, reqN_err=1, reqN_rdata=0, then follow REQ-013.
REQ-022 Without APB_ARB_TIMEOUT_EN, no counter SHALL exist, reqN_err SHALL be tied 0 and ACCESS SHALL wait indefinitely.

Structure
REQ-023 Package apb_arb_pkg SHALL hold the FSM state enum typedef and the grant-index typedef.
REQ-024 Round-robin decision SHALL live in sub-module apb_rr_arbiter (2 requests, mask input, last-grant state, grant output).

Verification
REQ-025 Single write: req0 addr=0x10, wdata=0xA5A5A5A5, pready=1 at once -> psel cycle 1, penable cycle 2, req0_done cycle 2, pwdata=0xA5A5A5A5.
REQ-026 Read with 3 wait states: req1 read addr=0x20, pready after 3 ACCESS cycles, prdata=0x1234 -> req1_done once, req1_rdata=0x1234, paddr stable throughout.
REQ-027 Contention: both valid from reset, continuously -> grants 0,1,0,1; ACCESS->SETUP back-to-back with no IDLE cycle.
REQ-028 Reset asserted mid-ACCESS -> psel/penable 0 same cycle, no done; after release req0 wins first.
REQ-029 APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready stuck 0 -> done+err after 4 ACCESS cycles, rdata=0; without macro transfer stays in ACCESS.
REQ-030 Bench SHALL bind APB protocol assertions (state order, signal stability, no X) to the APB outputs in all scenarios.
